// File: rtl/stream_merge_hub_if.sv
// Bundle of the hub's stream and exception signals.
// slave = the hub itself, master = producers/consumer/exception sources around it.
interface stream_merge_hub_if #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CHW      = 2
);
  // Packed so that channel i sits at flat bits [i*WIDTH +: WIDTH]
  logic [CHANNELS-1:0][WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]            in_stb;
  logic [CHANNELS-1:0]            in_last;
  logic [CHANNELS-1:0]            in_ack;
  logic [WIDTH-1:0]               out_data;
  logic                           out_last;
  logic [CHW-1:0]                 out_chan;
  logic                           out_stb;
  logic                           out_ack;
  logic [CHANNELS-1:0]            exc_in;
  logic                           exc_clear;
  logic                           exception;
  logic [CHW-1:0]                 exc_src;

  modport slave (
    input  in_data, in_stb, in_last, out_ack, exc_in, exc_clear,
    output in_ack, out_data, out_last, out_chan, out_stb, exception, exc_src
  );

  modport master (
    output in_data, in_stb, in_last, out_ack, exc_in, exc_clear,
    input  in_ack, out_data, out_last, out_chan, out_stb, exception, exc_src
  );
endinterface

// File: rtl/stream_merge_hub.sv
// N-to-1 packet-locked round-robin merge of stb/ack streams with a sticky exception.
// Optional stall watchdog: define STREAM_MERGE_HUB_WATCHDOG_EN.
module stream_merge_hub_lane #(
  parameter int CHW = 2,
  parameter int IDX = 0
) (
  input  logic           granting,
  input  logic [CHW-1:0] grant,
  input  logic           stb,
  input  logic           room,
  output logic           sel,
  output logic           ack
);
  assign sel = granting && (grant == CHW'(IDX));
  assign ack = sel && stb && room;
endmodule

module stream_merge_hub #(
  parameter int WIDTH    = 32,
  parameter int CHANNELS = 4,
  parameter int CHW      = 2,
  parameter int TIMEOUT  = 1024
) (
  input logic             clk,
  input logic             rst,
  stream_merge_hub_if.slave bus
);
  typedef enum logic {IDLE, GRANT} state_t;

  state_t              state;
  logic [CHW-1:0]      grant, last_grant, pick, exc_low;
  logic [CHANNELS-1:0] sel, ack, exc_vec;
  logic                room, xfer, xfer_last, wd_fire;
  logic [WIDTH-1:0]    out_data_q;
  logic                out_last_q, out_stb_q, exc_q;
  logic [CHW-1:0]      out_chan_q, exc_src_q;

  // A word may enter the output register when it is empty or draining this cycle.
  assign room = !out_stb_q || bus.out_ack;

  for (genvar i = 0; i < CHANNELS; i++) begin : g_lane
    stream_merge_hub_lane #(.CHW(CHW), .IDX(i)) u_lane (
      .granting (state == GRANT),
      .grant    (grant),
      .stb      (bus.in_stb[i]),
      .room     (room),
      .sel      (sel[i]),
      .ack      (ack[i])
    );
  end

  assign bus.in_ack = ack;
  assign xfer       = |ack;
  assign xfer_last  = bus.in_last[grant];

  // Round-robin: lowest requester above last_grant wins, else lowest at/below it.
  always_comb begin
    pick = '0;
    for (int i = CHANNELS-1; i >= 0; i--)
      if (bus.in_stb[i] && (CHW'(i) <= last_grant)) pick = CHW'(i);
    for (int i = CHANNELS-1; i >= 0; i--)
      if (bus.in_stb[i] && (CHW'(i) > last_grant)) pick = CHW'(i);
  end

`ifdef STREAM_MERGE_HUB_WATCHDOG_EN
  localparam int WDW = $clog2(TIMEOUT + 1);
  logic [WDW-1:0] wd_cnt;

  assign wd_fire = (state == GRANT) && !xfer && (wd_cnt == WDW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                  wd_cnt <= '0;
    else if (state != GRANT || xfer || wd_fire) wd_cnt <= '0;
    else                                       wd_cnt <= wd_cnt + 1'b1;
  end
`else
  assign wd_fire = 1'b0;
`endif

  // A watchdog release is reported as an exception from the stalled channel.
  assign exc_vec = bus.exc_in | (wd_fire ? sel : '0);

  always_comb begin
    exc_low = '0;
    for (int i = CHANNELS-1; i >= 0; i--)
      if (exc_vec[i]) exc_low = CHW'(i);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      grant      <= '0;
      last_grant <= CHW'(CHANNELS - 1);
      out_data_q <= '0;
      out_last_q <= 1'b0;
      out_chan_q <= '0;
      out_stb_q  <= 1'b0;
      exc_q      <= 1'b0;
      exc_src_q  <= '0;
    end else begin
      if (xfer) begin
        out_data_q <= bus.in_data[grant];
        out_last_q <= xfer_last;
        out_chan_q <= grant;
        out_stb_q  <= 1'b1;
      end else if (bus.out_ack) begin
        out_stb_q  <= 1'b0;
      end

      case (state)
        IDLE:
          if (|bus.in_stb) begin
            grant <= pick;
            state <= GRANT;
          end
        GRANT:
          if ((xfer && xfer_last) || wd_fire) begin
            last_grant <= grant;
            state      <= IDLE;
          end
        default: state <= IDLE;
      endcase

      if (|exc_vec) begin
        exc_q <= 1'b1;
        if (!exc_q || bus.exc_clear) exc_src_q <= exc_low;
      end else if (bus.exc_clear) begin
        exc_q <= 1'b0;
      end
    end
  end

  assign bus.out_data  = out_data_q;
  assign bus.out_last  = out_last_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_stb   = out_stb_q;
  assign bus.exception = exc_q;
  assign bus.exc_src   = exc_src_q;
endmodule

// File: tb/tb_stream_merge_hub.sv
// Scoreboard bench for stream_merge_hub: a packet-level round-robin model predicts
// the merged word stream; a monitor pops and compares on every output transfer.
module tb_stream_merge_hub;
  localparam int N = 4, W = 32, CW = 2, TO = 8;

  logic clk = 1'b0, rst = 1'b0;
  always #5 clk = ~clk;

  stream_merge_hub_if #(.WIDTH(W), .CHANNELS(N), .CHW(CW)) bus();
  stream_merge_hub #(.WIDTH(W), .CHANNELS(N), .CHW(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .bus(bus)
  );

  typedef struct {
    logic [CW-1:0] ch;
    logic [W-1:0]  d;
    logic          l;
  } exp_t;

  exp_t         sbq[$];
  logic [W-1:0] wd[N][$];
  bit           wl[N][$];
  int           plens[N][$];
  int           ptr[N], lim[N];
  int           out_cyc[$];
  int           out_cnt, cyc, m_last;
  int           n_tests, n_fail;
  bit           mon_en;
  exp_t         me;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (mon_en && rst && bus.out_stb && bus.out_ack) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $display("FAIL out_unexpected: got ch%0d %h, want nothing", bus.out_chan, bus.out_data);
      end else begin
        me = sbq.pop_front();
        if (me.ch !== bus.out_chan || me.d !== bus.out_data || me.l !== bus.out_last) begin
          n_fail++;
          $display("FAIL out_word: got ch%0d %h last=%0b, want ch%0d %h last=%0b",
                   bus.out_chan, bus.out_data, bus.out_last, me.ch, me.d, me.l);
        end
      end
      out_cyc.push_back(cyc);
      out_cnt++;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, want %0h", nm, got, want);
    end
  endtask

  task automatic push_exp(input int c, input logic [W-1:0] d, input bit l);
    exp_t e;
    e.ch = CW'(c); e.d = d; e.l = l;
    sbq.push_back(e);
  endtask

  task automatic clear_traffic();
    for (int c = 0; c < N; c++) begin
      wd[c].delete(); wl[c].delete(); plens[c].delete();
      ptr[c] = 0; lim[c] = 0;
    end
    sbq.delete();
  endtask

  task automatic add_pkt(input int c, input int len, input logic [W-1:0] base, input bit rnd);
    for (int i = 0; i < len; i++) begin
      wd[c].push_back(rnd ? W'($urandom) : base + W'(i));
      wl[c].push_back(i == len - 1);
    end
    plens[c].push_back(len);
    lim[c] += len;
  endtask

  // Whole packets, granted round-robin starting after the previous winner.
  task automatic build_model();
    int pi[N], wp[N];
    int found;
    for (int c = 0; c < N; c++) begin pi[c] = 0; wp[c] = 0; end
    while (1) begin
      found = -1;
      for (int k = 1; k <= N; k++)
        if (found < 0 && pi[(m_last + k) % N] < plens[(m_last + k) % N].size())
          found = (m_last + k) % N;
      if (found < 0) break;
      for (int j = 0; j < plens[found][pi[found]]; j++) begin
        push_exp(found, wd[found][wp[found]], wl[found][wp[found]]);
        wp[found]++;
      end
      pi[found]++;
      m_last = found;
    end
  endtask

  task automatic set_drv(input bit gap_en);
    bit sop;
    for (int c = 0; c < N; c++) begin
      if (ptr[c] < lim[c]) begin
        sop = (ptr[c] == 0) ? 1'b1 : wl[c][ptr[c] - 1];
        bus.in_stb[c]  = sop || !gap_en || ($urandom % 4 != 0);
        bus.in_data[c] = wd[c][ptr[c]];
        bus.in_last[c] = wl[c][ptr[c]];
      end else begin
        bus.in_stb[c]  = 1'b0;
        bus.in_data[c] = '0;
        bus.in_last[c] = 1'b0;
      end
    end
  endtask

  task automatic run(input bit gap_en, input bit ack_rand, input int hold_after, output int start);
    bit adv[N];
    bit held, hold_chk, done;
    int hold_cnt, guard;
    logic [W-1:0] held_d;
    held = 0; hold_cnt = 0; guard = 0; done = 0; held_d = '0;
    out_cyc.delete(); out_cnt = 0; mon_en = 1;
    @(posedge clk); #1;
    start = cyc;
    while (!done) begin
      set_drv(gap_en);
      if (!held && hold_after >= 0 && out_cnt == hold_after) begin
        held = 1; hold_cnt = 5; held_d = bus.out_data;
      end
      hold_chk = 0;
      if (hold_cnt > 0) begin
        bus.out_ack = 1'b0; hold_cnt--; hold_chk = 1;
      end else begin
        bus.out_ack = ack_rand ? ($urandom % 3 != 0) : 1'b1;
      end
      @(negedge clk);
      if (hold_chk) begin
        chk("hold_out_stb", 32'(bus.out_stb), 1);
        chk("hold_out_data", bus.out_data, held_d);
        chk("hold_in_ack", 32'(bus.in_ack), 0);
      end
      for (int c = 0; c < N; c++) adv[c] = bus.in_stb[c] && bus.in_ack[c];
      @(posedge clk); #1;
      for (int c = 0; c < N; c++) if (adv[c]) ptr[c]++;
      done = (sbq.size() == 0);
      for (int c = 0; c < N; c++) if (ptr[c] != lim[c]) done = 0;
      if (++guard > 3000) begin
        n_tests++; n_fail++;
        $display("FAIL run_timeout: got %0d words left, want 0", sbq.size());
        done = 1;
      end
    end
    bus.in_stb = '0; bus.out_ack = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b0; bus.in_stb = '0; bus.exc_in = '0; bus.exc_clear = 1'b0;
    m_last = N - 1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
  endtask

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    int s, adv_n, guard;
    bit m_exc;
    int m_src;
    bit clr;
    logic [N-1:0] ex;
    n_tests = 0; n_fail = 0; mon_en = 0; m_last = N - 1;
    bus.in_data = '0; bus.in_last = '0; bus.in_stb = '1;
    bus.out_ack = 1'b1; bus.exc_in = '0; bus.exc_clear = 1'b0;

    // Reset state, with every channel requesting
    @(negedge clk);
    chk("rst_out_stb", 32'(bus.out_stb), 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_last", 32'(bus.out_last), 0);
    chk("rst_out_chan", 32'(bus.out_chan), 0);
    chk("rst_exception", 32'(bus.exception), 0);
    chk("rst_exc_src", 32'(bus.exc_src), 0);
    chk("rst_in_ack", 32'(bus.in_ack), 0);
    do_reset();

    // 1: single packet from ch1, latency and out_last
    clear_traffic(); add_pkt(1, 3, 32'hA0, 0); build_model();
    run(0, 0, -1, s);
    chk("t1_count", out_cnt, 3);
    if (out_cyc.size() > 0) chk("t1_latency", out_cyc[0] - s, 2);

    // 2: ch0/ch2 backlogged 2-word packets, one arbitration cycle per packet
    do_reset();
    clear_traffic();
    add_pkt(0, 2, 32'h100, 0); add_pkt(0, 2, 32'h110, 0);
    add_pkt(2, 2, 32'h200, 0); add_pkt(2, 2, 32'h210, 0);
    build_model();
    run(0, 0, -1, s);
    chk("t2_count", out_cnt, 8);
    if (out_cyc.size() == 8) chk("t2_span", out_cyc[7] - out_cyc[0], 10);

    // 3: output backpressure for 5 cycles mid-packet
    clear_traffic(); add_pkt(2, 4, 32'h300, 0); build_model();
    run(0, 0, 2, s);
    chk("t3_count", out_cnt, 4);

    // Random packets with mid-packet gaps and random backpressure
    for (int r = 0; r < 4; r++) begin
      clear_traffic();
      for (int c = 0; c < N; c++)
        for (int p = $urandom_range(0, 3); p > 0; p--) add_pkt(c, $urandom_range(1, 4), '0, 1);
      build_model();
`ifdef STREAM_MERGE_HUB_WATCHDOG_EN
      run(0, 0, -1, s);
`else
      run(1, 1, -1, s);
`endif
    end

    // 4: sticky exception
    @(posedge clk); #1 bus.exc_in = 4'b0110;
    @(posedge clk); #1 bus.exc_in = '0;
    chk("t4_exc_set", 32'(bus.exception), 1);
    chk("t4_exc_src", 32'(bus.exc_src), 1);
    bus.exc_clear = 1'b1; bus.exc_in = 4'b1000;
    @(posedge clk); #1 bus.exc_clear = 1'b0; bus.exc_in = '0;
    chk("t4_clr_hit_exc", 32'(bus.exception), 1);
    chk("t4_clr_hit_src", 32'(bus.exc_src), 3);
    bus.exc_clear = 1'b1;
    @(posedge clk); #1 bus.exc_clear = 1'b0;
    chk("t4_cleared", 32'(bus.exception), 0);
    m_exc = 0; m_src = 3;
    repeat (40) begin
      ex = ($urandom % 3 == 0) ? N'($urandom) : '0;
      clr = ($urandom % 4 == 0);
      bus.exc_in = ex; bus.exc_clear = clr;
      if (ex != 0 && (!m_exc || clr)) m_src = lowest(ex);
      if (ex != 0) m_exc = 1; else if (clr) m_exc = 0;
      @(posedge clk); #1;
      chk("t4_rand_exc", 32'(bus.exception), 32'(m_exc));
      if (m_exc) chk("t4_rand_src", 32'(bus.exc_src), m_src);
    end
    bus.exc_in = 4'b0001; bus.exc_clear = 1'b0;
    @(posedge clk); #1 bus.exc_in = '0;

    // 5: reset after word 2 of a 4-word packet
    mon_en = 0; adv_n = 0; guard = 0;
    bus.in_data[0] = 32'h500; bus.in_last[0] = 1'b0; bus.in_stb[0] = 1'b1; bus.out_ack = 1'b1;
    while (adv_n < 2 && guard < 20) begin
      @(negedge clk);
      s = bus.in_ack[0] ? 1 : 0;
      @(posedge clk); #1;
      if (s == 1) begin adv_n++; bus.in_data[0] = 32'h500 + 32'(adv_n); end
      guard++;
    end
    chk("t5_pre_out_stb", 32'(bus.out_stb), 1);
    chk("t5_pre_out_data", bus.out_data, 32'h501);
    #1 rst = 1'b0;
    #1;
    chk("t5_out_stb", 32'(bus.out_stb), 0);
    chk("t5_out_data", bus.out_data, 0);
    chk("t5_out_last", 32'(bus.out_last), 0);
    chk("t5_out_chan", 32'(bus.out_chan), 0);
    chk("t5_exception", 32'(bus.exception), 0);
    chk("t5_exc_src", 32'(bus.exc_src), 0);
    chk("t5_in_ack", 32'(bus.in_ack), 0);
    bus.in_stb = '0;
    @(posedge clk); #1 rst = 1'b1; m_last = N - 1;
    clear_traffic(); add_pkt(3, 3, 32'h700, 0); build_model();
    run(0, 0, -1, s);
    chk("t5_count", out_cnt, 3);

`ifdef STREAM_MERGE_HUB_WATCHDOG_EN
    // 6: ch0 stalls after one word; watchdog hands the output to ch1
    do_reset();
    clear_traffic();
    add_pkt(0, 3, 32'h600, 0); lim[0] = 1;
    add_pkt(1, 2, 32'h610, 0);
    push_exp(0, 32'h600, 0); push_exp(1, 32'h610, 0); push_exp(1, 32'h611, 1);
    m_last = 1;
    run(0, 0, -1, s);
    chk("t6_exception", 32'(bus.exception), 1);
    chk("t6_exc_src", 32'(bus.exc_src), 0);
    if (out_cyc.size() >= 2) chk("t6_release_gap", out_cyc[1] - out_cyc[0], 10);
    else chk("t6_out_count", out_cyc.size(), 3);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
